// File: rtl/barcode_entry_register.sv
// Barcode entry register: the responder side of the sale-terminal digit entry path.
// It holds up to four digits in a shift register and reports completion.
// Illegal writes and writes beyond the fourth digit are refused with a reject pulse.
// A partial entry that sits idle for too long is cleared automatically.
module barcode_entry_register #(
    parameter int DIGIT_MAX      = 4,
    parameter int TIMEOUT_CYCLES = 250_000_000,
    parameter bit TIMEOUT_EN     = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       Barcode_Enable,
    input  logic       RSTN_BarcodeController_Pulse,
    input  logic [3:0] Barcode_Digit_in,
    output logic       BarcodeDigitCompleted,
    output logic [2:0] NumOfBarcodeDigitsEntered,
    output logic [3:0] Barcode_DigitOut_0,
    output logic [3:0] Barcode_DigitOut_1,
    output logic [3:0] Barcode_DigitOut_2,
    output logic [3:0] Barcode_DigitOut_3,
    output logic       Digit_Rejected,
    output logic       Entry_Timeout
);

    localparam int         CW        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [3:0] DMAX      = 4'(DIGIT_MAX);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_SAT  = '1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      count_q, count_d;
    logic [3:0]      d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic            done_q, done_d;
    logic            rej_q, rej_d;
    logic            tmo_q, tmo_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;

    logic clear, legal, expire, accept;

    // Next-state: clear beats timeout, and timeout beats any write on the same cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        rej_d   = 1'b0;
        tmo_d   = 1'b0;
        tcnt_d  = tcnt_q;

        clear  = !RSTN_BarcodeController_Pulse;
        legal  = (Barcode_Digit_in != 4'd0) && (Barcode_Digit_in <= DMAX);
        expire = TIMEOUT_EN && (state_q == PARTIAL) && (tcnt_q == TMO_LAST);
        accept = Barcode_Enable && legal && (state_q != FULL);

        if (clear || expire) begin
            state_d = EMPTY;
            count_d = 3'd0;
            d0_d    = 4'd0;
            d1_d    = 4'd0;
            d2_d    = 4'd0;
            d3_d    = 4'd0;
            tcnt_d  = '0;
            tmo_d   = !clear;
        end else if (accept) begin
            d3_d    = d2_q;
            d2_d    = d1_q;
            d1_d    = d0_q;
            d0_d    = Barcode_Digit_in;
            count_d = count_q + 3'd1;
            state_d = (count_q == 3'd3) ? FULL : PARTIAL;
            tcnt_d  = '0;
        end else begin
            // Refused writes leave the idle window running.
            rej_d = Barcode_Enable;
            if (TIMEOUT_EN && state_q == PARTIAL) begin
                if (tcnt_q != TMO_SAT)
                    tcnt_d = tcnt_q + 1'b1;
            end else begin
                tcnt_d = '0;
            end
        end

        done_d = (count_d == 3'd4);
    end

    // State and registered outputs, cleared asynchronously on RESET.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= EMPTY;
            count_q <= 3'd0;
            d0_q    <= 4'd0;
            d1_q    <= 4'd0;
            d2_q    <= 4'd0;
            d3_q    <= 4'd0;
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
            tmo_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            done_q  <= done_d;
            rej_q   <= rej_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign BarcodeDigitCompleted     = done_q;
    assign NumOfBarcodeDigitsEntered = count_q;
    assign Barcode_DigitOut_0        = d0_q;
    assign Barcode_DigitOut_1        = d1_q;
    assign Barcode_DigitOut_2        = d2_q;
    assign Barcode_DigitOut_3        = d3_q;
    assign Digit_Rejected            = rej_q;
    assign Entry_Timeout             = tmo_q;

endmodule

// File: tb/tb_barcode_entry_register.sv
// Directed bench for barcode_entry_register with a short timeout window (16 cycles).
module tb_barcode_entry_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       en = 1'b0;
    logic       clr_n = 1'b1;
    logic [3:0] din = 4'd0;
    logic       done, rej, tmo;
    logic [2:0] cnt;
    logic [3:0] o0, o1, o2, o3;

    int errors = 0;
    int checks = 0;

    barcode_entry_register #(
        .DIGIT_MAX(4),
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_EN(1'b1)
    ) dut (
        .CLOCK_50(clk),
        .RESET(rst),
        .Barcode_Enable(en),
        .RSTN_BarcodeController_Pulse(clr_n),
        .Barcode_Digit_in(din),
        .BarcodeDigitCompleted(done),
        .NumOfBarcodeDigitsEntered(cnt),
        .Barcode_DigitOut_0(o0),
        .Barcode_DigitOut_1(o1),
        .Barcode_DigitOut_2(o2),
        .Barcode_DigitOut_3(o3),
        .Digit_Rejected(rej),
        .Entry_Timeout(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [3:0] d);
        en  = 1'b1;
        din = d;
        step();
        en  = 1'b0;
    endtask

    task automatic clr();
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
    endtask

    task automatic chk_digits(input string tag, input logic [15:0] exp);
        chk({tag, ".digits"}, {o3, o2, o1, o0}, exp);
    endtask

    initial begin
        rst = 1'b1;
        #2;
        chk("rst.cnt", cnt, 0);
        chk_digits("rst", 16'h0000);
        chk("rst.done", done, 0);
        chk("rst.rej", rej, 0);
        chk("rst.tmo", tmo, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: fill with 3,1,4,2
        wr(4'd3);
        chk("t1.cnt1", cnt, 1);
        chk("t1.rej1", rej, 0);
        wr(4'd1);
        wr(4'd4);
        chk("t1.cnt3", cnt, 3);
        chk("t1.done3", done, 0);
        wr(4'd2);
        chk_digits("t1", 16'h3142);
        chk("t1.cnt4", cnt, 4);
        chk("t1.done4", done, 1);
        chk("t1.rej4", rej, 0);

        // 2: write when FULL is refused, then clear
        wr(4'd1);
        chk("t2.rej", rej, 1);
        chk_digits("t2", 16'h3142);
        chk("t2.cnt", cnt, 4);
        idle(1);
        chk("t2.rej_off", rej, 0);
        idle(20);
        chk("t2.full_no_tmo", cnt, 4);
        clr();
        chk("t2.clr_cnt", cnt, 0);
        chk_digits("t2.clr", 16'h0000);
        chk("t2.clr_done", done, 0);

        // 3: illegal digits in EMPTY
        wr(4'd0);
        chk("t3.rej0", rej, 1);
        chk("t3.cnt0", cnt, 0);
        wr(4'd5);
        chk("t3.rej5", rej, 1);
        chk("t3.cnt5", cnt, 0);
        wr(4'd2);
        chk("t3.rej2", rej, 0);
        chk("t3.o0", o0, 2);
        chk("t3.cnt", cnt, 1);

        // 4a: plain timeout, TIMEOUT_CYCLES cycles after the last accepted write
        clr();
        wr(4'd1);
        idle(15);
        chk("t4a.tmo_early", tmo, 0);
        chk("t4a.cnt_early", cnt, 1);
        idle(1);
        chk("t4a.tmo", tmo, 1);
        chk("t4a.rej", rej, 0);
        chk("t4a.cnt", cnt, 0);
        chk("t4a.o0", o0, 0);
        idle(1);
        chk("t4a.tmo_off", tmo, 0);

        // 4b: write at idle cycle 10 restarts the window
        wr(4'd1);
        idle(9);
        wr(4'd2);
        idle(6);
        chk("t4b.tmo_none", tmo, 0);
        chk("t4b.cnt", cnt, 2);
        idle(9);
        chk("t4b.tmo_early", tmo, 0);
        idle(1);
        chk("t4b.tmo", tmo, 1);
        chk("t4b.cnt0", cnt, 0);

        // 4c: rejected write does not restart the window
        wr(4'd1);
        idle(5);
        wr(4'd0);
        chk("t4c.rej", rej, 1);
        idle(9);
        chk("t4c.tmo_early", tmo, 0);
        idle(1);
        chk("t4c.tmo", tmo, 1);

        // 4d: write on the expiry cycle is dropped silently
        wr(4'd1);
        idle(15);
        wr(4'd3);
        chk("t4d.tmo", tmo, 1);
        chk("t4d.rej", rej, 0);
        chk("t4d.cnt", cnt, 0);
        chk("t4d.o0", o0, 0);

        // 5: clear beats enable
        wr(4'd1);
        wr(4'd2);
        chk("t5.cnt2", cnt, 2);
        en = 1'b1; din = 4'd3; clr_n = 1'b0;
        step();
        en = 1'b0; clr_n = 1'b1;
        chk("t5.cnt", cnt, 0);
        chk("t5.o0", o0, 0);
        chk("t5.rej", rej, 0);

        // 6: async reset mid-cycle
        wr(4'd1);
        wr(4'd2);
        wr(4'd3);
        chk("t6.cnt3", cnt, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6.cnt_rst", cnt, 0);
        chk_digits("t6.rst", 16'h0000);
        chk("t6.done_rst", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr(4'd4);
        chk("t6.cnt", cnt, 1);
        chk("t6.o0", o0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
